// File: rtl/ka_mul_sched_pkg.sv
// rtl/ka_mul_sched_pkg.sv - shared widths, FSM states and partial-product alignment for ka_mul_sched
package ka_mul_sched_pkg;

  localparam int wI   = 32;
  localparam int wO   = 2 * wI;
  localparam int NREQ = 2;
  localparam int HALF = wI / 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DONE
  } state_t;

  // Step k multiplies A half k[0] by B half k[1]; the shift is the sum of the half offsets.
  localparam logic [5:0] PP_SHIFT [4] = '{6'd0, 6'd16, 6'd16, 6'd32};

  function automatic logic [wO-1:0] pp_align(input logic [wI-1:0] pp, input logic [1:0] idx);
    return {{(wO - wI){1'b0}}, pp} << PP_SHIFT[idx];
  endfunction

endpackage

// File: rtl/ka_mul_sched_if.sv
// rtl/ka_mul_sched_if.sv - requester and product handshake bundle of ka_mul_sched
interface ka_mul_sched_if;
  import ka_mul_sched_pkg::*;

  logic [NREQ-1:0] iReqValid;
  logic [NREQ-1:0] oReqReady;
  logic [wI-1:0]   iA0;
  logic [wI-1:0]   iB0;
  logic [wI-1:0]   iA1;
  logic [wI-1:0]   iB1;
  logic            oValid;
  logic            iReady;
  logic [wO-1:0]   oProd;
  logic            oId;

  modport slave (
    input  iReqValid, iA0, iB0, iA1, iB1, iReady,
    output oReqReady, oValid, oProd, oId
  );

  modport master (
    output iReqValid, iA0, iB0, iA1, iB1, iReady,
    input  oReqReady, oValid, oProd, oId
  );

endinterface

// File: rtl/ka_mul16.sv
// rtl/ka_mul16.sv - shared 16x16 unsigned multiplier resource
module ka_mul16
  import ka_mul_sched_pkg::*;
(
  input  logic [HALF-1:0] a_i,
  input  logic [HALF-1:0] b_i,
  output logic [wI-1:0]   p_o
);

  assign p_o = {{HALF{1'b0}}, a_i} * {{HALF{1'b0}}, b_i};

endmodule

// File: rtl/ka_rr_arb2.sv
// rtl/ka_rr_arb2.sv - two-way round-robin grant; a tie goes to the requester not served last
module ka_rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_id_i,
  output logic [1:0] grant_o,
  output logic       grant_id_o
);

  assign grant_id_o = valid_i[1] & (~valid_i[0] | ~last_id_i);
  assign grant_o    = (valid_i == 2'b00) ? 2'b00 : (grant_id_o ? 2'b10 : 2'b01);

endmodule

// File: rtl/ka_mul_sched.sv
// rtl/ka_mul_sched.sv - round-robin scheduler building 32x32 products from four 16x16 steps
// KA_MUL_SCHED_PPREG_EN registers the multiplier output, adding one cycle of latency.
module ka_mul_sched
  import ka_mul_sched_pkg::*;
(
  input  logic           iClk,
  input  logic           iRst,
  ka_mul_sched_if.slave  bus
);

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            last_id_q, last_id_d;
  logic            id_q, id_d;
  logic [wI-1:0]   a_q, a_d, b_q, b_d;
  logic [wO-1:0]   acc_q, acc_d;

  logic [1:0]      grant;
  logic            grant_id;
  logic [HALF-1:0] mul_a, mul_b;
  logic [wI-1:0]   mul_p;
  logic [wO-1:0]   add_term;
  logic            add_en;
  logic            last_step;

  ka_rr_arb2 u_arb (
    .valid_i    (bus.iReqValid),
    .last_id_i  (last_id_q),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );

  assign mul_a = cnt_q[0] ? a_q[wI-1:HALF] : a_q[HALF-1:0];
  assign mul_b = cnt_q[1] ? b_q[wI-1:HALF] : b_q[HALF-1:0];

  ka_mul16 u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

`ifdef KA_MUL_SCHED_PPREG_EN
  logic [wI-1:0] pp_q, pp_d;

  assign pp_d      = (state_q == ST_MUL) ? mul_p : pp_q;
  // Accumulation trails issue by one step, so align with the previous step's shift.
  assign add_term  = pp_align(pp_q, cnt_q[1:0] - 2'd1);
  assign add_en    = (cnt_q != 3'd0);
  assign last_step = (cnt_q == 3'd4);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) pp_q <= '0;
    else      pp_q <= pp_d;
  end
`else
  assign add_term  = pp_align(mul_p, cnt_q[1:0]);
  assign add_en    = 1'b1;
  assign last_step = (cnt_q == 3'd3);
`endif

  assign bus.oReqReady = (state_q == ST_IDLE && !iRst) ? grant : 2'b00;
  assign bus.oValid    = (state_q == ST_DONE);
  assign bus.oProd     = acc_q;
  assign bus.oId       = id_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_id_d = last_id_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.oReqReady) begin
          a_d       = grant_id ? bus.iA1 : bus.iA0;
          b_d       = grant_id ? bus.iB1 : bus.iB0;
          id_d      = grant_id;
          last_id_d = grant_id;
          acc_d     = '0;
          cnt_d     = 3'd0;
          state_d   = ST_MUL;
        end
      end
      ST_MUL: begin
        if (add_en) acc_d = acc_q + add_term;
        cnt_d = cnt_q + 3'd1;
        if (last_step) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.iReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      last_id_q <= 1'b1;
      id_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_id_q <= last_id_d;
      id_q      <= id_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
    end
  end

endmodule

// File: tb/tb_ka_mul_sched.sv
// tb/tb_ka_mul_sched.sv - directed and randomized checks of ka_mul_sched against a transaction model
module tb_ka_mul_sched;
  import ka_mul_sched_pkg::*;

`ifdef KA_MUL_SCHED_PPREG_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ka_mul_sched_if bus ();

  ka_mul_sched dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  typedef struct { logic id; logic [63:0] prod; int acc_cyc; } exp_t;
  typedef struct { logic id; logic [63:0] prod; } done_t;

  exp_t  exp_q[$];
  done_t done_q[$];
  int    acc_hist[$];
  logic  acc_id_hist[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [1:0]  v;
  logic [31:0] a[2];
  logic [31:0] b[2];
  logic        rdy;
  logic        model_last;
  logic [1:0]  acc_pend;
  logic        hs_pend;
  logic        in_done;
  logic [1:0]  keep;
  logic        raise_en;
  logic        rdy_rand;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive();
    bus.iReqValid = v;
    bus.iA0       = a[0];
    bus.iB0       = b[0];
    bus.iA1       = a[1];
    bus.iB1       = b[1];
    bus.iReady    = rdy;
  endtask

  task automatic model_clear();
    exp_q.delete();
    acc_pend   = 2'b00;
    hs_pend    = 1'b0;
    in_done    = 1'b0;
    model_last = 1'b1;
  endtask

  // One clock: retire last edge's handshakes, update stimulus, then compare settled outputs.
  task automatic cycle();
    logic [1:0] g;
    logic       gid;
    logic       eid;
    exp_t       e;
    @(posedge clk);
    #1;
    cyc++;
    if (hs_pend) begin
      void'(exp_q.pop_front());
      hs_pend = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (acc_pend[i]) begin
        acc_pend[i] = 1'b0;
        if (keep[i]) begin
          a[i] = rand_op();
          b[i] = rand_op();
        end else begin
          v[i] = 1'b0;
        end
      end
    end
    if (raise_en) begin
      for (int i = 0; i < 2; i++) begin
        if (!v[i] && $urandom_range(0, 3) == 0) begin
          v[i] = 1'b1;
          a[i] = rand_op();
          b[i] = rand_op();
        end
      end
    end
    if (rdy_rand) rdy = ($urandom_range(0, 2) != 0);
    drive();
    #1;
    g = bus.oReqReady;
    check("ready_onehot", 64'($countones(g) <= 1), 64'd1);
    check("ready_without_valid", {62'b0, g & ~v}, 64'd0);
    if ((g & v) != 2'b00) begin
      gid = g[1];
      eid = (v == 2'b11) ? ~model_last : v[1];
      check("grant_id", {63'b0, gid}, {63'b0, eid});
      check("accept_while_busy", 64'(exp_q.size()), 64'd0);
      e.id      = eid;
      e.prod    = {32'b0, a[eid]} * {32'b0, b[eid]};
      e.acc_cyc = cyc;
      exp_q.push_back(e);
      acc_hist.push_back(cyc);
      acc_id_hist.push_back(gid);
      model_last    = eid;
      acc_pend[gid] = 1'b1;
    end
    if (bus.oValid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 64'd1, 64'd0);
      end else begin
        if (!in_done) check("latency", 64'(cyc - exp_q[0].acc_cyc), 64'(LAT));
        check("prod", bus.oProd, exp_q[0].prod);
        check("id", {63'b0, bus.oId}, {63'b0, exp_q[0].id});
        check("ready_in_done", {62'b0, g}, 64'd0);
        if (rdy) begin
          hs_pend = 1'b1;
          done_q.push_back('{bus.oId, bus.oProd});
        end
      end
      in_done = !rdy;
    end else begin
      in_done = 1'b0;
    end
  endtask

  task automatic run_until_idle(input string tag, input int max);
    for (int k = 0; k < max; k++) begin
      if (exp_q.size() == 0 && v == 2'b00 && acc_pend == 2'b00 && !hs_pend) break;
      cycle();
    end
    check({tag, "_drain"}, 64'(exp_q.size() != 0 || v != 2'b00), 64'd0);
  endtask

  task automatic check_done(input string tag, input int idx, input logic id, input logic [63:0] prod);
    if (done_q.size() <= idx) begin
      check({tag, "_missing"}, 64'(done_q.size()), 64'(idx + 1));
    end else begin
      check({tag, "_id"}, {63'b0, done_q[idx].id}, {63'b0, id});
      check({tag, "_prod"}, done_q[idx].prod, prod);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v   = 2'b11;
    drive();
    #1;
    check("rst_ready", {62'b0, bus.oReqReady}, 64'd0);
    check("rst_valid", {63'b0, bus.oValid}, 64'd0);
    check("rst_prod", bus.oProd, 64'd0);
    check("rst_id", {63'b0, bus.oId}, 64'd0);
    repeat (2) @(posedge clk);
    v = 2'b00;
    drive();
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    done_q.delete();
  endtask

  task automatic single(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [63:0] prod);
    done_q.delete();
    v    = 2'b01;
    a[0] = aa;
    b[0] = bb;
    run_until_idle(tag, 60);
    check_done(tag, 0, 1'b0, prod);
  endtask

  initial begin
    int n;
    v        = 2'b00;
    a[0]     = '0; b[0] = '0; a[1] = '0; b[1] = '0;
    rdy      = 1'b1;
    keep     = 2'b00;
    raise_en = 1'b0;
    rdy_rand = 1'b0;
    model_clear();
    drive();
    #2;
    do_reset();

    single("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);

    do_reset();
    v    = 2'b11;
    a[0] = 32'd3;       b[0] = 32'd5;
    a[1] = 32'h1_0000;  b[1] = 32'h1_0000;
    run_until_idle("tie", 60);
    check_done("tie0", 0, 1'b0, 64'd15);
    check_done("tie1", 1, 1'b1, 64'h1_0000_0000);

    acc_hist.delete();
    acc_id_hist.delete();
    keep = 2'b10;
    v    = 2'b10;
    a[1] = rand_op();
    b[1] = rand_op();
    n = 0;
    while (acc_hist.size() < 4 && n < 80) begin cycle(); n++; end
    check("b2b_count", 64'(acc_hist.size()), 64'd4);
    repeat (2) cycle();
    v[0] = 1'b1;
    a[0] = 32'hDEAD_BEEF;
    b[0] = 32'h0BAD_F00D;
    n = 0;
    while (acc_hist.size() < 5 && n < 40) begin cycle(); n++; end
    keep = 2'b00;
    run_until_idle("b2b", 60);
    for (int i = 1; i < 4; i++) begin
      if (acc_hist.size() > i) check("b2b_gap", 64'(acc_hist[i] - acc_hist[i-1]), 64'(LAT + 1));
    end
    if (acc_id_hist.size() > 4) check("mid_mul_req0_next", {63'b0, acc_id_hist[4]}, 64'd0);
    else check("mid_mul_req0_missing", 64'(acc_id_hist.size()), 64'd5);

    done_q.delete();
    rdy  = 1'b0;
    v    = 2'b01;
    a[0] = 32'h1234_5678;
    b[0] = 32'h9ABC_DEF0;
    repeat (LAT + 11) cycle();
    check("hold_valid", {63'b0, bus.oValid}, 64'd1);
    check("hold_prod", bus.oProd, 64'h0B00_EA4E_242D_2080);
    rdy = 1'b1;
    run_until_idle("hold", 20);
    check_done("hold", 0, 1'b0, 64'h0B00_EA4E_242D_2080);

    acc_hist.delete();
    v    = 2'b01;
    a[0] = 32'hCAFE_F00D;
    b[0] = 32'h8765_4321;
    n = 0;
    while (acc_hist.size() < 1 && n < 20) begin cycle(); n++; end
    repeat (3) cycle();
    do_reset();
    repeat (LAT + 3) cycle();
    check("post_rst_valid", {63'b0, bus.oValid}, 64'd0);
    single("post_rst", 32'd7, 32'd9, 64'd63);

    single("zero", 32'h0, 32'hFFFF_FFFF, 64'd0);

    raise_en = 1'b1;
    rdy_rand = 1'b1;
    repeat (800) cycle();
    raise_en = 1'b0;
    rdy_rand = 1'b0;
    rdy      = 1'b1;
    run_until_idle("random", 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
